// File: rtl/inst_status_responder.sv
// Pass tracker for the attention controller: counts Q/K/P writes,
// load and exec cycles, sequences the pass and latches the first misuse.
module inst_status_responder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned LD_CYCLES   = 8,
    parameter int unsigned EXEC_CYCLES = 8,
    parameter int unsigned OFIFO_LAT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [19:0] inst,
    output logic        q_full,
    output logic        k_full,
    output logic        ld_done,
    output logic        exec_done,
    output logic        out_wr,
    output logic        p_full,
    output logic [2:0]  phase,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LD_CYCLES + 1);
    localparam int EW = $clog2(EXEC_CYCLES + 1);
    localparam int TW = $clog2(OFIFO_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_QW   = 3'd1,
        S_KW   = 3'd2,
        S_LD   = 3'd3,
        S_EX   = 3'd4,
        S_OH   = 3'd5,
        S_PW   = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] q_cnt_q, q_cnt_d;
    logic [DW-1:0] k_cnt_q, k_cnt_d;
    logic [LW-1:0] l_cnt_q, l_cnt_d;
    logic [EW-1:0] e_cnt_q, e_cnt_d;
    logic [DW-1:0] p_cnt_q, p_cnt_d;
    logic [TW-1:0] lat_q, lat_d;
    logic          lat_run_q, lat_run_d;
    logic          q_full_q, q_full_d;
    logic          k_full_q, k_full_d;
    logic          ld_done_q, ld_done_d;
    logic          ex_done_q, ex_done_d;
    logic          out_wr_q, out_wr_d;
    logic          p_full_q, p_full_d;
    logic          err_q, err_d;
    logic [2:0]    code_q, code_d;

    logic q_wr, k_wr, ld, ex_rd, ex_go;
    logic p_wr, p_rd, of_rd, ex_rise;

    assign q_wr  = inst[4];
    assign k_wr  = inst[2];
    assign ld    = inst[6];
    assign ex_go = inst[7];
    assign ex_rd = inst[5];
    assign p_wr  = inst[0];
    assign p_rd  = inst[1];
    assign of_rd = inst[16];

    // Counters saturate by gating on their own done flag.
    always_comb begin
        q_cnt_d   = q_cnt_q;
        k_cnt_d   = k_cnt_q;
        l_cnt_d   = l_cnt_q;
        e_cnt_d   = e_cnt_q;
        p_cnt_d   = p_cnt_q;
        q_full_d  = q_full_q;
        k_full_d  = k_full_q;
        ld_done_d = ld_done_q;
        ex_done_d = ex_done_q;
        p_full_d  = p_full_q;
        if (q_wr && !q_full_q) begin
            q_cnt_d = q_cnt_q + DW'(1);
            if (q_cnt_d == DW'(DEPTH)) q_full_d = 1'b1;
        end
        if (k_wr && !k_full_q) begin
            k_cnt_d = k_cnt_q + DW'(1);
            if (k_cnt_d == DW'(DEPTH)) k_full_d = 1'b1;
        end
        if (ld && !ld_done_q) begin
            l_cnt_d = l_cnt_q + LW'(1);
            if (l_cnt_d == LW'(LD_CYCLES)) ld_done_d = 1'b1;
        end
        if (ex_go && ex_rd && !ex_done_q) begin
            e_cnt_d = e_cnt_q + EW'(1);
            if (e_cnt_d == EW'(EXEC_CYCLES)) ex_done_d = 1'b1;
        end
        if (p_wr && of_rd && !p_full_q) begin
            p_cnt_d = p_cnt_q + DW'(1);
            if (p_cnt_d == DW'(DEPTH)) p_full_d = 1'b1;
        end
    end

    assign ex_rise = ex_done_d && !ex_done_q;

    // lat_q reads 1 in the first cycle exec_done is visible.
    always_comb begin
        lat_d     = lat_q;
        lat_run_d = lat_run_q;
        out_wr_d  = out_wr_q;
        if (ex_rise) begin
            lat_d     = TW'(1);
            lat_run_d = 1'b1;
        end else if (lat_run_q) begin
            if (lat_q == TW'(OFIFO_LAT)) begin
                out_wr_d  = 1'b1;
                lat_run_d = 1'b0;
            end else begin
                lat_d = lat_q + TW'(1);
            end
        end
        if (out_wr_q && of_rd) out_wr_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (q_wr) state_d = S_QW;
            S_QW:   if (k_wr) state_d = S_KW;
            S_KW:   if (ld) state_d = S_LD;
            S_LD:   if (ex_go) state_d = S_EX;
            S_EX:   if (ex_rise) state_d = S_OH;
            S_OH: begin
                if (of_rd && p_wr) state_d = S_PW;
            end
            S_PW:   if (p_full_q) state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lowest code wins when several violations share a cycle.
    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        if (!err_q) begin
            if (q_wr && k_wr) begin
                err_d  = 1'b1;
                code_d = 3'd1;
            end else if (ex_go && !ld_done_q) begin
                err_d  = 1'b1;
                code_d = 3'd2;
            end else if (p_wr && p_rd) begin
                err_d  = 1'b1;
                code_d = 3'd3;
            end else if (of_rd && !out_wr_q &&
                         state_q != S_PW) begin
                err_d  = 1'b1;
                code_d = 3'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            q_cnt_q   <= '0;
            k_cnt_q   <= '0;
            l_cnt_q   <= '0;
            e_cnt_q   <= '0;
            p_cnt_q   <= '0;
            lat_q     <= '0;
            lat_run_q <= 1'b0;
            q_full_q  <= 1'b0;
            k_full_q  <= 1'b0;
            ld_done_q <= 1'b0;
            ex_done_q <= 1'b0;
            out_wr_q  <= 1'b0;
            p_full_q  <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 3'd0;
        end else if (clr) begin
            state_q   <= S_IDLE;
            q_cnt_q   <= '0;
            k_cnt_q   <= '0;
            l_cnt_q   <= '0;
            e_cnt_q   <= '0;
            p_cnt_q   <= '0;
            lat_q     <= '0;
            lat_run_q <= 1'b0;
            q_full_q  <= 1'b0;
            k_full_q  <= 1'b0;
            ld_done_q <= 1'b0;
            ex_done_q <= 1'b0;
            out_wr_q  <= 1'b0;
            p_full_q  <= 1'b0;
            err_q     <= err_d;
            code_q    <= code_d;
        end else begin
            state_q   <= state_d;
            q_cnt_q   <= q_cnt_d;
            k_cnt_q   <= k_cnt_d;
            l_cnt_q   <= l_cnt_d;
            e_cnt_q   <= e_cnt_d;
            p_cnt_q   <= p_cnt_d;
            lat_q     <= lat_d;
            lat_run_q <= lat_run_d;
            q_full_q  <= q_full_d;
            k_full_q  <= k_full_d;
            ld_done_q <= ld_done_d;
            ex_done_q <= ex_done_d;
            out_wr_q  <= out_wr_d;
            p_full_q  <= p_full_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign q_full    = q_full_q;
    assign k_full    = k_full_q;
    assign ld_done   = ld_done_q;
    assign exec_done = ex_done_q;
    assign out_wr    = out_wr_q;
    assign p_full    = p_full_q;
    assign phase     = state_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_inst_status_responder.sv
// Scoreboard bench: timestamp/count reference model feeds a queue,
// a negedge monitor pops and compares the registered outputs.
module tb_inst_status_responder;

    localparam int DEPTH = 8;
    localparam int LDC   = 8;
    localparam int EXC   = 8;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [19:0] inst;
    logic        q_full, k_full, ld_done, exec_done;
    logic        out_wr, p_full, err;
    logic [2:0]  phase, err_code;

    always #5 clk = ~clk;

    inst_status_responder #(
        .DEPTH(DEPTH), .LD_CYCLES(LDC),
        .EXEC_CYCLES(EXC), .OFIFO_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .clr(clr), .inst(inst),
        .q_full(q_full), .k_full(k_full), .ld_done(ld_done),
        .exec_done(exec_done), .out_wr(out_wr), .p_full(p_full),
        .phase(phase), .err(err), .err_code(err_code)
    );

    typedef struct {
        logic [12:0] v;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;

    // Reference model: event counts, pass step, and the
    // cycle index at which exec_done became visible.
    int mq, mk, ml, me, mp, mst, mcode;
    int mnow, rise_at;
    bit merr, rd, mow;

    function automatic logic [12:0] mvec();
        return {mq >= DEPTH, mk >= DEPTH, ml >= LDC,
                me >= EXC, mow, mp >= DEPTH,
                3'(mst), merr, 3'(mcode)};
    endfunction

    task automatic model_step(input bit r, input bit c,
                              input logic [19:0] i);
        bit ldd, exo, pf, rose;
        int code;
        if (r) begin
            mq = 0; mk = 0; ml = 0; me = 0; mp = 0;
            mst = 0; merr = 0; mcode = 0;
            rise_at = -1; rd = 0;
        end else begin
            ldd  = ml >= LDC;
            exo  = me >= EXC;
            pf   = mp >= DEPTH;
            code = 0;
            if (i[4] && i[2]) code = 1;
            else if (i[7] && !ldd) code = 2;
            else if (i[0] && i[1]) code = 3;
            else if (i[16] && !mow && mst != 6) code = 4;
            if (!merr && code != 0) begin
                merr  = 1;
                mcode = code;
            end
            if (c) begin
                mq = 0; mk = 0; ml = 0; me = 0; mp = 0;
                mst = 0; rise_at = -1; rd = 0;
            end else begin
                if (i[4] && mq < DEPTH) mq++;
                if (i[2] && mk < DEPTH) mk++;
                if (i[6] && ml < LDC) ml++;
                if (i[7] && i[5] && me < EXC) me++;
                if (i[0] && i[16] && mp < DEPTH) mp++;
                rose = !exo && me >= EXC;
                if (rose) rise_at = mnow + 1;
                if (i[16] && mow) rd = 1;
                case (mst)
                    0: if (i[4]) mst = 1;
                    1: if (i[2]) mst = 2;
                    2: if (i[6]) mst = 3;
                    3: if (i[7]) mst = 4;
                    4: if (rose) mst = 5;
                    5: if (i[16] && i[0]) mst = 6;
                    6: if (pf) mst = 7;
                    default: ;
                endcase
            end
        end
        mnow++;
        mow = rise_at >= 0 && mnow >= rise_at + LAT && !rd;
    endtask

    task automatic cyc(input bit r, input bit c,
                       input logic [19:0] i);
        exp_t e;
        reset = r;
        clr   = c;
        inst  = i;
        model_step(r, c, i);
        @(posedge clk);
        #1;
        e.v  = mvec();
        e.id = ncyc;
        sb.push_back(e);
        ncyc++;
    endtask

    function automatic logic [19:0] junk();
        return {3'($urandom), 15'b0, 1'($urandom), 1'b0};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [12:0] got;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {q_full, k_full, ld_done, exec_done, out_wr,
                   p_full, phase, err, err_code};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL outs cyc=%0d got=%b exp=%b",
                         e.id, got, e.v);
            end
        end
    end

    task automatic pass(input int stop_ex, input bit extra_q);
        int n, b;
        for (int j = 0; j < DEPTH; j++) cyc(0, 0, 20'h10 | junk());
        if (extra_q) cyc(0, 0, 20'h10 | junk());
        cyc(0, 0, junk());
        for (int j = 0; j < DEPTH; j++) cyc(0, 0, 20'h04 | junk());
        cyc(0, 0, junk());
        for (int j = 0; j < LDC; j++) cyc(0, 0, 20'h40 | junk());
        cyc(0, 0, junk());
        n = 0;
        while (n < stop_ex) begin
            if ($urandom_range(3) == 0) begin
                cyc(0, 0, 20'h80 | junk());
            end else begin
                cyc(0, 0, 20'hA0 | junk());
                n++;
            end
        end
        if (stop_ex >= EXC) begin
            b = 0;
            while (!mow && b < 20) begin
                cyc(0, 0, junk());
                b++;
            end
            for (int j = 0; j < DEPTH; j++)
                cyc(0, 0, (20'h10001 | junk()) & ~20'h2);
            cyc(0, 0, junk());
            cyc(0, 0, junk());
        end
    endtask

    initial begin
        int b;
        logic [19:0] ri;
        mnow = 0;
        mow  = 0;
        rise_at = -1;
        for (int j = 0; j < 2; j++)
            cyc(1, 1'($urandom), 20'($urandom));
        pass(EXC, 1'b1);
        cyc(0, 1, 20'h10);
        for (int j = 0; j < DEPTH - 1; j++) cyc(0, 0, 20'h10);
        cyc(0, 0, 20'h0);
        cyc(1, 0, 20'h0);
        pass(5, 1'b0);
        cyc(1, 0, junk());
        cyc(0, 0, 20'h0);
        pass(EXC, 1'b0);
        cyc(1, 0, 20'h0);
        cyc(0, 0, 20'h14);
        cyc(0, 0, 20'h80);
        cyc(0, 0, 20'h0);
        cyc(1, 0, 20'h0);
        cyc(0, 0, 20'h10000);
        cyc(0, 1, 20'h0);
        cyc(1, 0, 20'h0);
        cyc(0, 0, 20'h3);
        cyc(1, 0, 20'h0);
        cyc(0, 0, 20'h10083);
        cyc(1, 0, 20'h0);
        cyc(0, 0, 20'h10016);
        for (int j = 0; j < 600; j++) begin
            ri = '0;
            for (int k = 0; k < 20; k++)
                if ($urandom_range(3) == 0) ri[k] = 1'b1;
            cyc($urandom_range(63) == 0,
                $urandom_range(40) == 0, ri);
        end
        reset = 1'b0;
        clr   = 1'b0;
        inst  = '0;
        b = 0;
        while (sb.size() > 0 && b < 10) begin
            @(posedge clk);
            b++;
        end
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
